control_unit_mc: RTL

Multicycle control unit for the RV32I-subset core. It decodes the opcode and funct fields of the instruction register and sequences a Moore FSM, one instruction over 3–5 cycles. It sits directly upstream of the datapath and drives every mux select, write enable and ALU control, so the datapath can share one memory port and one ALU across fetch, address and execute steps.

---
 rtl/uc_defs.sv | 66 ++++++
 rtl/control_unit_mc_alu_decoder.sv | 37 +++
 rtl/control_unit_mc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uc_defs.sv
// Shared definitions for the multicycle control unit and its datapath.
//   - FSM state encodings (0..10)
//   - supported opcodes
//   - ALUOp codes (FSM -> ALU decoder)
//   - ALUControl codes (shared with the ALU)
//   - ALUSrcA / ALUSrcB / resSrc / inmSrc select codes (shared with the datapath)
package uc_defs;

    // FSM state encodings
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    // Opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Datapath select codes
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/control_unit_mc_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction funct bits to the ALU operation.
// Purely combinational.
//   alu_op      in  2  ALUOp from the FSM
//   f3          in  3  instr[14:12]
//   op5         in  1  instr[5], separates R (register) from I (immediate)
//   f7          in  1  instr[30]
//   alu_control out 3  ALU operation code
module alu_decoder
    import uc_defs::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] f3,
    input  logic       op5,
    input  logic       f7,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (f3)
                    // addi has no sub form, so instr[30] only counts for R-type
                    3'b000:  alu_control = (op5 & f7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle control unit for the RV32I-subset core. Moore FSM sequencing
// fetch / decode / address / memory / execute / writeback steps so the
// datapath can share one memory port and one ALU.
//   clk, rst           clock, synchronous active-high reset
//   op, f3, f7         instruction fields from the instruction register
//   zero               ALU result == 0, used in BEQ only
//   pcWrite, adrSrc, memWrite, irWrite, regWrite   datapath enables/selects
//   resSrc, ALUSrcA, ALUSrcB, ALUControl, inmSrc   datapath mux/ALU controls
//   illegal            one-cycle flag in DECODE for an unsupported opcode
//   state              current FSM state (debug)
module control_unit_mc
    import uc_defs::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic [2:0]         f3,
    input  logic               f7,
    input  logic               zero,
    output logic               pcWrite,
    output logic               adrSrc,
    output logic               memWrite,
    output logic               irWrite,
    output logic [1:0]         resSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         inmSrc,
    output logic               regWrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0] FETCH    = STATE_W'(S_FETCH);
    localparam logic [STATE_W-1:0] DECODE   = STATE_W'(S_DECODE);
    localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(S_MEMADR);
    localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(S_MEMREAD);
    localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(S_MEMWB);
    localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(S_MEMWRITE);
    localparam logic [STATE_W-1:0] EXECR    = STATE_W'(S_EXECR);
    localparam logic [STATE_W-1:0] EXECI    = STATE_W'(S_EXECI);
    localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(S_ALUWB);
    localparam logic [STATE_W-1:0] JAL      = STATE_W'(S_JAL);
    localparam logic [STATE_W-1:0] BEQ      = STATE_W'(S_BEQ);

    logic [STATE_W-1:0] st, st_next;
    logic               pc_update, branch;
    logic [1:0]         alu_op;

    always_ff @(posedge clk) begin
        if (rst) st <= FETCH;
        else     st <= st_next;
    end

    always_comb begin
        st_next = FETCH;
        case (st)
            FETCH:  st_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: st_next = MEMADR;
                    OP_R:         st_next = EXECR;
                    OP_I:         st_next = EXECI;
                    OP_JAL:       st_next = JAL;
                    OP_BEQ:       st_next = BEQ;
                    default:      st_next = FETCH;
                endcase
            end
            MEMADR:   st_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  st_next = MEMWB;
            EXECR, EXECI, JAL: st_next = ALUWB;
            default:  st_next = FETCH;  // MEMWB, MEMWRITE, ALUWB, BEQ, unused codes
        endcase
    end

    always_comb begin
        irWrite   = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        regWrite  = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        resSrc    = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALUOP_ADD;
        case (st)
            FETCH: begin
                irWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                resSrc    = RES_ALURESULT;
                pc_update = 1'b1;
            end
            DECODE: begin
                // precompute branch/jump target from oldPC + imm
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD:  adrSrc = 1'b1;
            MEMWB: begin
                resSrc   = RES_MEMDATA;
                regWrite = 1'b1;
            end
            MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            ALUWB:    regWrite = 1'b1;
            JAL: begin
                // ALU forms oldPC + 4 for rd while PC takes the target from ALUOut
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            BEQ: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase

        // Reset masks all enables and parks the muxes on their FETCH settings
        if (rst) begin
            irWrite   = 1'b0;
            adrSrc    = 1'b0;
            memWrite  = 1'b0;
            regWrite  = 1'b0;
            pc_update = 1'b0;
            branch    = 1'b0;
            resSrc    = RES_ALURESULT;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            alu_op    = ALUOP_ADD;
        end
    end

    assign pcWrite = pc_update | (branch & zero);
    assign illegal = ~rst & (st == DECODE) & ~op_supported(op);
    assign state   = st;

    always_comb begin
        case (op)
            OP_SW:   inmSrc = IMM_S;
            OP_BEQ:  inmSrc = IMM_B;
            OP_JAL:  inmSrc = IMM_J;
            default: inmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .f3          (f3),
        .op5         (op[5]),
        .f7          (f7),
        .alu_control (ALUControl)
    );

endmodule
